// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter for one single-port synchronous memory,
// with a bounded hold under contention and read data tagged back to the issuing master.
module mem_arbiter #(
    parameter int AW       = 7,
    parameter int DW       = 10,
    parameter int MAX_HOLD = 4
) (
    input  logic          Clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          grant0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          grant1,
    output logic          rvalid1,
    input  logic [DW-1:0] mem_q,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic [DW-1:0] rdata
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t        state, next;
    logic [HW-1:0] hold;
    logic          prio, acc0, acc1, at_max, req_other;
    assign at_max    = hold == HW'(MAX_HOLD - 1);
    assign req_other = state == OWN0 ? req1 : state == OWN1 ? req0 : 1'b0;
    always_ff @(posedge Clock) begin
        if (!reset) begin
            state   <= IDLE;
            hold    <= '0;
            prio    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state   <= next;
            hold    <= (next != state || !req_other) ? '0 : (acc0 || acc1) ? hold + HW'(1) : hold;
            prio    <= (state == OWN0 && next != OWN0) ? 1'b1 : (state == OWN1 && next != OWN1) ? 1'b0 : prio;
            // rvalid follows the issuer of the read, independent of where the grant has moved
            rvalid0 <= acc0 && !we0;
            rvalid1 <= acc1 && !we1;
        end
    end
    always_comb begin
        next = state == IDLE ? ((req0 && req1) ? (prio ? OWN1 : OWN0) : req0 ? OWN0 : req1 ? OWN1 : IDLE)
             : state == OWN0 ? (!req0 ? (req1 ? OWN1 : IDLE) : (req1 && at_max) ? OWN1 : OWN0)
             : (!req1 ? (req0 ? OWN0 : IDLE) : (req0 && at_max) ? OWN0 : OWN1);
    end
    always_comb begin
        grant0    = state == OWN0;
        grant1    = state == OWN1;
        acc0      = grant0 && req0;
        acc1      = grant1 && req1;
        mem_we    = acc0 ? we0 : acc1 && we1;
        mem_addr  = acc0 ? addr0 : acc1 ? addr1 : '0;
        mem_wdata = acc0 ? wdata0 : acc1 ? wdata1 : '0;
        rdata     = mem_q;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port synchronous memory between two bus masters, for example the processor core and a DMA/IO engine.
- Each master presents address, write data and write-enable under a request line.
- The arbiter grants one master at a time using round-robin priority with a bounded hold, and steers the master's signals to the memory.
- Read data returns one cycle after the access, tagged to the owning master.

Parameters:
AW, 7, address width in bits
DW, 10, data word width in bits
MAX_HOLD, 4, maximum consecutive accesses by one owner while the other master is requesting (minimum 1)

Ports:
Clock  input  1  system clock, rising-edge
reset  input  1  synchronous, active-low reset (0 = reset)
req0  input  1  master 0 access request
we0  input  1  master 0 write enable (1 = write, 0 = read)
addr0  input  AW  master 0 address
wdata0  input  DW  master 0 write data
grant0  output  1  master 0 owns the memory
rvalid0  output  1  read data valid for master 0
req1  input  1  master 1 access request
we1  input  1  master 1 write enable
addr1  input  AW  master 1 address
wdata1  input  DW  master 1 write data
grant1  output  1  master 1 owns the memory
rvalid1  output  1  read data valid for master 1
mem_q  input  DW  memory read data; 1-cycle synchronous read
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_we  output  1  memory write enable
rdata  output  DW  read data to masters; equals mem_q

Behaviour:
- Reset, sampled on a Clock edge with reset = 0:
  - state = IDLE; grant0 = grant1 = 0; rvalid0 = rvalid1 = 0.
  - Hold counter = 0; priority pointer favours master 0.
  - Reset overrides every other event, including a mid-transaction access: that access is dropped and no rvalid follows.
- States: IDLE, OWN0, OWN1. grant0 = (state == OWN0) and grant1 = (state == OWN1), both registered.
- IDLE transitions:
  - Only req0 -> OWN0. Only req1 -> OWN1.
  - Both requesting -> the master favoured by the pointer.
  - Neither -> stay in IDLE.
- OWNx transitions:
  - reqx = 0 -> go to OWNy if reqy = 1, else IDLE.
  - reqx = 1, reqy = 1 and hold counter == MAX_HOLD-1 -> go to OWNy directly. Handover has no dead cycle.
  - Otherwise stay in OWNx.
- Hold counter:
  - Increments on each access cycle in OWNx.
  - Clears on entry to any state and whenever reqy = 0.
  - An uncontested owner therefore holds indefinitely.
- Priority pointer: on leaving OWNx, the pointer favours the other master.
- Access cycle: a cycle with grantx = 1 and reqx = 1.
  - mem_addr = addrx, mem_wdata = wdatax, mem_we = wex. These are combinational muxes from the owner.
  - No access cycle -> mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - mem_we is never 1 without a grant.
- Latency:
  - The first access happens on the cycle after req is sampled with grant = 0, so grant appears 1 cycle after req.
  - A master sees its grant before it issues accesses.
- Read return: a read access cycle at edge t produces rvaldx = 1 during cycle t+1 with rdata = mem_q. Exactly one rvalid pulse per read; none for writes.
- Handover with reads in flight: rvalid is tagged to the master that issued the read, even if the grant has already moved. rvalid0 and rvalid1 are never both 1.
- A master that drops req mid-grant issues no access that cycle. It loses the grant at the next edge.

Test Plan:
- Single master: reset, then req0 = 1, we0 = 0, addr0 = 5 with memory[5] = 0x155 -> grant0 = 1 one cycle after req0; mem_addr = 5 while granted; rvalid0 = 1 with rdata = 0x155 one cycle after the access; grant1 and rvalid1 stay 0.
- Simultaneous first request: req0 = req1 = 1 from IDLE after reset -> grant0 first. After 4 access cycles (MAX_HOLD = 4), grant1 = 1 on the next edge with no idle cycle. After 4 more cycles, grant returns to master 0.
- Write gating: master 1 owns with we1 = 1, addr1 = 3, wdata1 = 0x2AA -> mem_we = 1, mem_wdata = 0x2AA, memory[3] = 0x2AA. Master 0 driving we0 = 1 while ungranted -> mem_we never reflects it.
- Handover with read in flight: master 0 reads addr 7 on its last hold cycle -> next cycle grant1 = 1, rvalid0 = 1, rvalid1 = 0, rdata = memory[7].
- Release and idle: owner drops req with other idle -> state IDLE next edge, both grants 0, mem_we = 0, mem_addr = 0.
- Reset mid-operation: reset = 0 during a granted read -> next cycle all grants and rvalids are 0. On reset = 1 with both requesting, master 0 wins.
